wb_decoder_watchdog: RTL

- Wishbone address decoder and bus watchdog. Sits directly downstream of the core/debug Wishbone controller and consumes its single master port (adr/dat/sel/we/cyc/stb).
- Routes each request to one of NUM_SLAVES peripherals and returns that slave's dat/ack/err to the master.
- Generates the master's err response for unmapped addresses and for slaves that fail to ack within TIMEOUT_CYCLES. This guarantees the combinational controller never stalls the pipeline forever.

---
 rtl/wb_decoder_watchdog.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/wb_decoder_watchdog.sv
// -----------------------------------------------------------------------------
// wb_decoder_watchdog
//
// Purpose:
//   Wishbone address decoder and bus watchdog placed directly after the single
//   core/debug Wishbone master. Each request is routed combinationally to one of
//   NUM_SLAVES peripherals. The selected slave's dat/ack/err is returned to the
//   master. The block answers with a one-cycle err in two cases:
//     - the address hits no slave region (decode error);
//     - a forwarded request gets no ack/err within TIMEOUT_CYCLES (timeout).
//   This guarantees the master never waits forever.
//
// Optional feature (macro WB_ERR_LOG_EN):
//   When defined, the first error seen on m_err_o is captured in a sticky log
//   (address + cause). The log keeps that entry until err_log_clr_i is asserted.
//   When the macro is undefined, the err_log_* outputs are tied to zero and
//   err_log_clr_i is ignored.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   m_adr_i/m_dat_i/m_sel_i/m_we_i/m_cyc_i/m_stb_i
//                           master request
//   m_dat_o/m_ack_o/m_err_o response to master
//   s_adr_o/s_dat_o/s_sel_o/s_we_o
//                           shared slave request fields (direct copies)
//   s_cyc_o/s_stb_o         per-slave cycle/strobe (one-hot or zero)
//   s_dat_i/s_ack_i/s_err_i per-slave response, slave i at [32*i +: 32] / [i]
//   err_log_clr_i           clears the error log
//   err_log_valid_o/err_log_addr_o/err_log_cause_o
//                           first logged error. Cause codes:
//                           01 decode, 10 timeout, 11 slave err
// -----------------------------------------------------------------------------
module wb_decoder_watchdog #(
    parameter int                      NUM_SLAVES     = 4,
    parameter logic [8*NUM_SLAVES-1:0] SLAVE_REGIONS  = 32'h40_30_20_00,
    parameter int                      TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [31:0]                m_adr_i,
    input  logic [31:0]                m_dat_i,
    input  logic [3:0]                 m_sel_i,
    input  logic                       m_we_i,
    input  logic                       m_cyc_i,
    input  logic                       m_stb_i,
    output logic [31:0]                m_dat_o,
    output logic                       m_ack_o,
    output logic                       m_err_o,
    output logic [31:0]                s_adr_o,
    output logic [31:0]                s_dat_o,
    output logic [3:0]                 s_sel_o,
    output logic                       s_we_o,
    output logic [NUM_SLAVES-1:0]      s_cyc_o,
    output logic [NUM_SLAVES-1:0]      s_stb_o,
    input  logic [32*NUM_SLAVES-1:0]   s_dat_i,
    input  logic [NUM_SLAVES-1:0]      s_ack_i,
    input  logic [NUM_SLAVES-1:0]      s_err_i,
    input  logic                       err_log_clr_i,
    output logic                       err_log_valid_o,
    output logic [31:0]                err_log_addr_o,
    output logic [1:0]                 err_log_cause_o
);

    // A 1-bit counter is kept when the watchdog is disabled so that no
    // zero-width vector is ever declared.
    localparam int              CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] CAUSE_DECODE  = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [1:0] CAUSE_SLAVE   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACTIVE  = 2'b01,
        ST_ERR_RSP = 2'b10
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_err_cause;

    logic                w_req;
    logic                w_hit;
    logic                w_live;
    logic                w_fwd;
    logic                w_err_rsp;
    logic                w_sel_ack;
    logic                w_sel_err;
    logic [NUM_SLAVES-1:0] w_match;
    logic [NUM_SLAVES-1:0] w_sel_oh;
    logic [31:0]         w_sel_dat;

    assign w_req = m_cyc_i & m_stb_i;

    // Region comparison for every slave port.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_match[i] = (m_adr_i[31:24] == SLAVE_REGIONS[8*i +: 8]);
        end
    end

    // Isolating the lowest set bit gives the lowest-index-wins priority
    // without a priority-if chain.
    assign w_hit    = |w_match;
    assign w_sel_oh = w_match & (~w_match + NUM_SLAVES'(1));

    // AND-OR mux of the selected slave's read data (w_sel_oh is one-hot or zero).
    always_comb begin
        w_sel_dat = 32'h0000_0000;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_sel_dat = w_sel_dat | (s_dat_i[32*i +: 32] & {32{w_sel_oh[i]}});
        end
    end

    assign w_sel_ack = |(s_ack_i & w_sel_oh);
    assign w_sel_err = |(s_err_i & w_sel_oh);

    // reset_n gates the datapath so that asserting reset drops strobes and
    // responses at once, without waiting for a clock edge.
    assign w_err_rsp = reset_n & (r_state == ST_ERR_RSP);
    assign w_live    = reset_n & (r_state != ST_ERR_RSP);
    assign w_fwd     = w_req & w_hit & w_live;

    assign s_adr_o = m_adr_i;
    assign s_dat_o = m_dat_i;
    assign s_sel_o = m_sel_i;
    assign s_we_o  = m_we_i;
    assign s_cyc_o = w_sel_oh & {NUM_SLAVES{w_fwd}};
    assign s_stb_o = w_sel_oh & {NUM_SLAVES{w_fwd}};

    // A slave raising ack and err together is reported as err only.
    assign m_ack_o = w_fwd & w_sel_ack & ~w_sel_err;
    assign m_err_o = (w_fwd & w_sel_err) | (w_err_rsp & m_cyc_i);
    assign m_dat_o = w_fwd ? w_sel_dat : 32'h0000_0000;

    // Request tracking FSM: decode errors, watchdog counting, one-cycle err response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_err_cause <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req && !w_hit) begin
                        r_state     <= ST_ERR_RSP;
                        r_cnt       <= '0;
                        r_err_cause <= CAUSE_DECODE;
                    end else if (w_fwd && !(w_sel_ack || w_sel_err)) begin
                        r_state <= ST_ACTIVE;
                        r_cnt   <= CNT_W'(1);
                    end else begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (!w_fwd) begin
                        // Master abandoned the request: no error is reported.
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_sel_ack || w_sel_err) begin
                        // A response in the last counted cycle beats the watchdog.
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == CNT_TO)) begin
                        r_state     <= ST_ERR_RSP;
                        r_cnt       <= '0;
                        r_err_cause <= CAUSE_TIMEOUT;
                    end else begin
                        r_state <= ST_ACTIVE;
                        r_cnt   <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
                    end
                end
                ST_ERR_RSP: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef WB_ERR_LOG_EN
    logic        r_log_valid;
    logic [31:0] r_log_addr;
    logic [1:0]  r_log_cause;
    logic [1:0]  w_log_cause;

    // Outside ERR_RSP the only possible m_err_o source is the slave itself.
    assign w_log_cause = w_err_rsp ? r_err_cause : CAUSE_SLAVE;

    // Sticky first-error capture. A new error wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_log_valid <= 1'b0;
            r_log_addr  <= 32'h0000_0000;
            r_log_cause <= 2'b00;
        end else if (m_err_o && (!r_log_valid || err_log_clr_i)) begin
            r_log_valid <= 1'b1;
            r_log_addr  <= m_adr_i;
            r_log_cause <= w_log_cause;
        end else if (err_log_clr_i) begin
            r_log_valid <= 1'b0;
            r_log_addr  <= 32'h0000_0000;
            r_log_cause <= 2'b00;
        end else begin
            r_log_valid <= r_log_valid;
            r_log_addr  <= r_log_addr;
            r_log_cause <= r_log_cause;
        end
    end

    assign err_log_valid_o = r_log_valid;
    assign err_log_addr_o  = r_log_addr;
    assign err_log_cause_o = r_log_cause;
`else
    logic [2:0] w_unused_log;

    assign w_unused_log    = {err_log_clr_i, r_err_cause};
    assign err_log_valid_o = 1'b0;
    assign err_log_addr_o  = 32'h0000_0000;
    assign err_log_cause_o = 2'b00;
`endif

endmodule
